// File: rtl/hedios_host.sv
// UART host that sends a 6-byte command frame to a HEDIOS endpoint and collects its response.
// Optional response timeout is enabled by defining HEDIOS_HOST_TIMEOUT_EN.
module hedios_host #(
    parameter int unsigned CLK_RATE       = 24_414,
    parameter int unsigned BAUD_RATE      = 2_400,
    parameter int unsigned TIMEOUT_CYCLES = 2_000
) (
    input  logic        slower_clock,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [7:0]  req_index,
    input  logic [31:0] req_param,
    output logic        tx_line,
    input  logic        rx_line,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic        busy
);
    localparam int unsigned CLKS_PER_BIT = CLK_RATE / BAUD_RATE;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID    = CW'(CLKS_PER_BIT / 2);

    if (CLKS_PER_BIT < 4 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("hedios_host: CLKS_PER_BIT must be >= 4 and TIMEOUT_CYCLES > 0");
    end

    typedef enum logic [2:0] {IDLE, SEND, WAIT_RSP, RECV, DONE} state_t;

    state_t          r_state, w_next;
    logic [1:0]      r_op;
    logic [7:0]      r_index;
    logic [31:0]     r_param;
    logic            r_tx;
    logic [CW-1:0]   r_tx_cnt;
    logic [3:0]      r_tx_bit;
    logic [2:0]      r_tx_byte;
    logic            r_rx_s1, r_rx_s2, r_rx_prev;
    logic [CW-1:0]   r_rx_cnt;
    logic [3:0]      r_rx_bit;
    logic [1:0]      r_rx_byte;
    logic [7:0]      r_rx_shift;
    logic [23:0]     r_rx_acc;
    logic            r_rsp_valid;
    logic [31:0]     r_rsp_data;
    logic [1:0]      r_rsp_status;

    logic            w_accept, w_tx_end, w_rx_fall, w_rx_mid, w_rx_stop;
    logic            w_frm_err, w_last_byte, w_timeout;
    logic [47:0]     w_frame;
    logic [7:0]      w_tx_byte;

    assign w_accept    = req_valid && req_ready;
    assign w_frame     = {r_param, r_index, 6'b000000, r_op};
    assign w_tx_byte   = w_frame[{r_tx_byte, 3'b000} +: 8];
    assign w_tx_end    = (r_state == SEND) && (r_tx_cnt == CNT_LAST) &&
                         (r_tx_bit == 4'd9) && (r_tx_byte == 3'd5);
    assign w_rx_fall   = r_rx_prev && !r_rx_s2;
    assign w_rx_mid    = (r_state == RECV) && (r_rx_cnt == CNT_MID);
    assign w_rx_stop   = w_rx_mid && (r_rx_bit == 4'd9);
    assign w_frm_err   = w_rx_stop && !r_rx_s2;
    assign w_last_byte = (r_op != 2'b00) || (r_rx_byte == 2'd3);

`ifdef HEDIOS_HOST_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_to_cnt;

    assign w_timeout = (r_state == WAIT_RSP) && (r_to_cnt == TW'(TIMEOUT_CYCLES));

    // Counts idle cycles while waiting for each response byte.
    always_ff @(posedge slower_clock or posedge rst) begin
        if (rst)
            r_to_cnt <= '0;
        else if (w_tx_end || (w_rx_stop && !w_frm_err && !w_last_byte) ||
                 (r_state == WAIT_RSP && w_rx_fall))
            r_to_cnt <= '0;
        else if (r_state == WAIT_RSP)
            r_to_cnt <= r_to_cnt + TW'(1);
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge slower_clock or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_next = SEND;
            SEND:     if (w_tx_end) w_next = WAIT_RSP;
            WAIT_RSP: begin
                if (w_timeout)      w_next = DONE;
                else if (w_rx_fall) w_next = RECV;
            end
            RECV:     if (w_rx_stop) w_next = (w_frm_err || w_last_byte) ? DONE : WAIT_RSP;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Datapath: TX serializer, RX synchronizer/deserializer, response registers.
    always_ff @(posedge slower_clock or posedge rst) begin
        if (rst) begin
            r_op         <= '0;
            r_index      <= '0;
            r_param      <= '0;
            r_tx         <= 1'b1;
            r_tx_cnt     <= '0;
            r_tx_bit     <= '0;
            r_tx_byte    <= '0;
            r_rx_s1      <= 1'b1;
            r_rx_s2      <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_byte    <= '0;
            r_rx_shift   <= '0;
            r_rx_acc     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_status <= '0;
        end else begin
            r_rx_s1     <= rx_line;
            r_rx_s2     <= r_rx_s1;
            r_rx_prev   <= r_rx_s2;
            r_rsp_valid <= (w_next == DONE);
            case (r_state)
                IDLE: if (w_accept) begin
                    r_op         <= req_op;
                    r_index      <= req_index;
                    r_param      <= req_param;
                    r_tx         <= 1'b0;
                    r_tx_cnt     <= '0;
                    r_tx_bit     <= '0;
                    r_tx_byte    <= '0;
                    r_rx_byte    <= '0;
                    r_rsp_data   <= '0;
                    r_rsp_status <= '0;
                end
                SEND: begin
                    if (r_tx_cnt == CNT_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 4'd9) begin
                            r_tx_bit <= '0;
                            if (r_tx_byte == 3'd5) begin
                                r_tx <= 1'b1;
                            end else begin
                                r_tx_byte <= r_tx_byte + 3'd1;
                                r_tx      <= 1'b0;
                            end
                        end else begin
                            r_tx_bit <= r_tx_bit + 4'd1;
                            r_tx     <= (r_tx_bit == 4'd8) ? 1'b1 : w_tx_byte[r_tx_bit[2:0]];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CW'(1);
                    end
                end
                WAIT_RSP: begin
                    if (w_timeout) begin
                        r_rsp_status <= 2'b10;
                        r_rsp_data   <= '0;
                    end else if (w_rx_fall) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                    end
                end
                RECV: begin
                    if (r_rx_cnt == CNT_LAST) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= r_rx_bit + 4'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                    if (w_rx_mid && r_rx_bit >= 4'd1 && r_rx_bit <= 4'd8)
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                    if (w_frm_err) begin
                        r_rsp_status <= 2'b11;
                        r_rsp_data   <= '0;
                    end else if (w_rx_stop) begin
                        if (r_op == 2'b00) begin
                            r_rx_acc  <= {r_rx_shift, r_rx_acc[23:8]};
                            r_rx_byte <= r_rx_byte + 2'd1;
                            if (r_rx_byte == 2'd3) begin
                                r_rsp_data   <= {r_rx_shift, r_rx_acc};
                                r_rsp_status <= 2'b00;
                            end
                        end else begin
                            r_rsp_data   <= '0;
                            r_rsp_status <= (r_rx_shift == 8'hAA) ? 2'b00 : 2'b01;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE) && !rst;
    assign busy       = (r_state != IDLE);
    assign tx_line    = r_tx;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_status = r_rsp_status;
endmodule

// File: tb/tb_hedios_host.sv
// Directed, table-driven bench for hedios_host with a bit-level UART endpoint model (CLKS_PER_BIT = 10).
module tb_hedios_host;
    localparam int CPB = 10;
    localparam int TO  = 100;

    logic        slower_clock = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [7:0]  req_index = '0;
    logic [31:0] req_param = '0;
    logic        tx_line;
    logic        rx_line = 1'b1;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        busy;

    hedios_host #(.CLK_RATE(24_000), .BAUD_RATE(2_400), .TIMEOUT_CYCLES(TO)) dut (
        .slower_clock(slower_clock), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_index(req_index), .req_param(req_param), .tx_line(tx_line),
        .rx_line(rx_line), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_status(rsp_status), .busy(busy)
    );

    always #5 slower_clock = ~slower_clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge slower_clock) cyc <= cyc + 1;

    // Response monitor: latches every rsp_valid pulse for later comparison.
    int          pulses = 0, high_samples = 0, lat_cyc = 0;
    logic [31:0] lat_data;
    logic [1:0]  lat_status;
    logic        lat_ready, lat_ready_after, prev_valid = 1'b0;
    always @(negedge slower_clock) begin
        if (rsp_valid) begin
            high_samples <= high_samples + 1;
            if (!prev_valid) begin
                pulses     <= pulses + 1;
                lat_data   <= rsp_data;
                lat_status <= rsp_status;
                lat_ready  <= req_ready;
                lat_cyc    <= cyc;
            end
        end
        if (prev_valid && !rsp_valid) lat_ready_after <= req_ready;
        prev_valid <= rsp_valid;
    end

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  idx;
        logic [31:0] param;
        int          n_rsp;
        logic [31:0] rsp;
        int          bad;
        logic [31:0] exp_data;
        logic [1:0]  exp_st;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_tx(input logic [1:0] op, input logic [7:0] idx,
                                          input logic [31:0] param, input int i);
        logic [31:0] p;
        p = param;
        case (i)
            0: return {6'b000000, op};
            1: return idx;
            2: return p[7:0];
            3: return p[15:8];
            4: return p[23:16];
            default: return p[31:24];
        endcase
    endfunction

    task automatic issue(input logic [1:0] op, input logic [7:0] idx, input logic [31:0] param,
                         output int ca);
        int n;
        n = 0;
        @(negedge slower_clock);
        while (!req_ready && n < 500) begin @(negedge slower_clock); n++; end
        if (!req_ready) chk("req_ready_wait", 32'(req_ready), 32'd1);
        req_op = op; req_index = idx; req_param = param; req_valid = 1'b1;
        @(negedge slower_clock);
        req_valid = 1'b0;
        ca = cyc;
        chk("start_bit_next_cycle", 32'(tx_line), 32'd0);
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("ready_after_accept", 32'(req_ready), 32'd0);
    endtask

    task automatic capture_frame(input logic [1:0] op, input logic [7:0] idx,
                                 input logic [31:0] param, input int ca);
        logic [7:0] b;
        int n;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            while (tx_line && n < 40) begin @(negedge slower_clock); n++; end
            chk("tx_byte_start_time", 32'(cyc), 32'(ca + i * 10 * CPB));
            repeat (CPB / 2) @(negedge slower_clock);
            chk("tx_start_bit", 32'(tx_line), 32'd0);
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) @(negedge slower_clock);
                b[k] = tx_line;
            end
            chk("tx_byte", 32'(b), 32'(exp_tx(op, idx, param, i)));
            repeat (CPB) @(negedge slower_clock);
            chk("tx_stop_bit", 32'(tx_line), 32'd1);
        end
        repeat (CPB) @(negedge slower_clock);
        chk("tx_idle_after_frame", 32'(tx_line), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge slower_clock);
        rx_line = 1'b0;
        repeat (CPB) @(negedge slower_clock);
        for (int k = 0; k < 8; k++) begin
            rx_line = b[k];
            repeat (CPB) @(negedge slower_clock);
        end
        rx_line = stop;
        repeat (CPB) @(negedge slower_clock);
        rx_line = 1'b1;
        repeat (3) @(negedge slower_clock);
    endtask

    task automatic run_vec(input int v);
        int ca, p0, h0, n;
        logic [31:0] r;
        p0 = pulses; h0 = high_samples;
        issue(vecs[v].op, vecs[v].idx, vecs[v].param, ca);
        capture_frame(vecs[v].op, vecs[v].idx, vecs[v].param, ca);
        chk("busy_wait_rsp", 32'(busy), 32'd1);
        r = vecs[v].rsp;
        for (int i = 0; i < vecs[v].n_rsp; i++) begin
            send_byte(r[8*i +: 8], (i == vecs[v].bad) ? 1'b0 : 1'b1);
            if (i == vecs[v].bad) break;
        end
        n = 0;
        while (pulses == p0 && n < 300) begin @(negedge slower_clock); n++; end
        repeat (3) @(negedge slower_clock);
        chk("rsp_pulse_count", 32'(pulses - p0), 32'd1);
        chk("rsp_pulse_width", 32'(high_samples - h0), 32'd1);
        chk("rsp_data", lat_data, vecs[v].exp_data);
        chk("rsp_status", 32'(lat_status), 32'(vecs[v].exp_st));
        chk("ready_in_done", 32'(lat_ready), 32'd0);
        chk("ready_after_done", 32'(lat_ready_after), 32'd1);
    endtask

    initial begin
        int ca, p0, n;
        vecs[0] = '{2'b00, 8'h03, 32'hDEADBEEF, 4, 32'h12345678, -1, 32'h12345678, 2'b00};
        vecs[1] = '{2'b10, 8'h00, 32'h000000A5, 1, 32'h000000AA, -1, 32'h00000000, 2'b00};
        vecs[2] = '{2'b01, 8'h07, 32'h00000000, 1, 32'h00000055, -1, 32'h00000000, 2'b01};
        vecs[3] = '{2'b01, 8'h07, 32'h00000000, 1, 32'h000000AA,  0, 32'h00000000, 2'b11};
        vecs[4] = '{2'b11, 8'hFF, 32'h12345678, 1, 32'h000000AA, -1, 32'h00000000, 2'b00};
        vecs[5] = '{2'b00, 8'h01, 32'h00000000, 4, 32'h04030201,  2, 32'h00000000, 2'b11};
        vecs[6] = '{2'b00, 8'h80, 32'hC0FFEE01, 4, 32'h00FF00FF, -1, 32'h00FF00FF, 2'b00};

        repeat (2) @(negedge slower_clock);
        chk("rst_tx_line", 32'(tx_line), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_status", 32'(rsp_status), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(negedge slower_clock);
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        for (int v = 0; v < 7; v++) run_vec(v);

        // Reset during the start bit of TX byte 3.
        p0 = pulses;
        issue(2'b10, 8'h11, 32'h33221100, ca);
        repeat (30 * CPB + 2 - 1) @(negedge slower_clock);
        chk("tx_low_before_rst", 32'(tx_line), 32'd0);
        rst = 1'b1;
        #1;
        chk("midtx_rst_tx_line", 32'(tx_line), 32'd1);
        chk("midtx_rst_busy", 32'(busy), 32'd0);
        chk("midtx_rst_ready", 32'(req_ready), 32'd0);
        chk("midtx_rst_data", rsp_data, 32'd0);
        repeat (3) @(negedge slower_clock);
        rst = 1'b0;
        repeat (20) @(negedge slower_clock);
        chk("midtx_no_rsp", 32'(pulses - p0), 32'd0);
        chk("midtx_ready_again", 32'(req_ready), 32'd1);

        // RX traffic while idle must not wake the FSM.
        n = 0;
        fork
            send_byte(8'hAA, 1'b1);
            repeat (12 * CPB) begin @(negedge slower_clock); if (busy) n++; end
        join
        chk("idle_rx_busy_cycles", 32'(n), 32'd0);
        chk("idle_rx_no_rsp", 32'(pulses - p0), 32'd0);

        run_vec(0);

        // No reply from endpoint.
        p0 = pulses;
        issue(2'b01, 8'h42, 32'h0, ca);
        capture_frame(2'b01, 8'h42, 32'h0, ca);
`ifdef HEDIOS_HOST_TIMEOUT_EN
        n = 0;
        while (pulses == p0 && n < TO + 100) begin @(negedge slower_clock); n++; end
        repeat (2) @(negedge slower_clock);
        chk("timeout_pulse", 32'(pulses - p0), 32'd1);
        chk("timeout_latency", 32'(lat_cyc), 32'(ca + 60 * CPB + TO + 1));
        chk("timeout_status", 32'(lat_status), 32'd2);
        chk("timeout_data", lat_data, 32'd0);
`else
        repeat (3 * TO) @(negedge slower_clock);
        chk("no_timeout_busy", 32'(busy), 32'd1);
        chk("no_timeout_no_rsp", 32'(pulses - p0), 32'd0);
        rst = 1'b1;
        @(negedge slower_clock);
        rst = 1'b0;
        @(negedge slower_clock);
        chk("recover_ready", 32'(req_ready), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hedios_host.md
HEDIOS_HOST -- requirements
Module: hedios_host

Interface
REQ-001 SHALL have parameter CLK_RATE, default 24_414; slower_clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 2_400; UART bit rate. CLKS_PER_BIT = CLK_RATE/BAUD_RATE (integer), SHALL be >= 4.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2_000; response timeout in slower_clock cycles.
REQ-004 slower_clock  input  1  clock, all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-008 req_op  input  2  00 read slot, 01 varless action, 10 var action, 11 reset device.
REQ-009 req_index  input  8  slot/action index.
REQ-010 req_param  input  32  var-action parameter (sent for all ops).
REQ-011 tx_line  output  1  UART to endpoint, idle high.
REQ-012 rx_line  input  1  UART from endpoint, asynchronous.
REQ-013 rsp_valid  output  1  one-cycle pulse, response complete.
REQ-014 rsp_data  output  32  read-slot data; 0 for other ops or on error.
REQ-015 rsp_status  output  2  00 ok, 01 bad ack, 10 timeout, 11 framing error.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states IDLE, SEND, WAIT_RSP, RECV, DONE; req_ready = (state == IDLE).
REQ-018 On acceptance: latch op/index/param, go SEND; start bit begins on the next cycle.
REQ-019 Frame SHALL be 6 bytes back-to-back: {000000,op}, index, param[7:0], [15:8], [23:16], [31:24].
REQ-020 Each byte: start bit 0, 8 data bits LSB first, stop bit 1, each exactly CLKS_PER_BIT cycles; full frame = 60*CLKS_PER_BIT cycles.
REQ-021 After last stop bit ends: go WAIT_RSP; tx_line high.
REQ-022 rx_line SHALL pass a 2-flop synchronizer; start detected on synchronized falling edge, bits sampled at CLKS_PER_BIT/2 into each bit.
REQ-023 Expected response: op 00 -> 4 bytes, LSB first, into rsp_data; ops 01/10/11 -> 1 ack byte 0xAA.
REQ-024 Ack byte != 0xAA -> rsp_status 01, rsp_data 0.
REQ-025 Sampled stop bit 0 on any response byte -> abort reception, rsp_status 11, rsp_data 0.
REQ-026 RX activity in IDLE or SEND SHALL be ignored; no state change.
REQ-027 WAIT_RSP -> RECV on start-bit detect; RECV -> WAIT_RSP between read bytes; last byte done -> DONE.
REQ-028 DONE lasts one cycle: rsp_valid=1, then IDLE; rsp_data/rsp_status hold until next acceptance.
REQ-029 New request SHALL NOT be accepted in the DONE cycle; earliest acceptance is the cycle after.

Reset
REQ-030 rst asserted SHALL immediately force IDLE, tx_line=1, rsp_valid=0, rsp_data=0, rsp_status=00, busy=0, req_ready=0 while rst high, then 1.
REQ-031 Reset mid-frame (TX or RX) SHALL discard the transaction; no rsp_valid pulse is produced.

Configuration
REQ-032 Macro HEDIOS_HOST_TIMEOUT_EN defined: counter clears on entering WAIT_RSP and on each start-bit detect, increments in WAIT_RSP; at TIMEOUT_CYCLES -> DONE with rsp_status 10, rsp_data 0.
REQ-033 Macro not defined: no timeout counter; WAIT_RSP waits indefinitely; status 10 never produced.

Verification (CLKS_PER_BIT=10)
REQ-034 op 00, index 0x03; endpoint model replies 0x78,0x56,0x34,0x12 -> tx frame 01?? no: bytes 0x00,0x03,param bytes; rsp_valid once, rsp_data 0x12345678, status 00.
REQ-035 op 10, index 0x00, param 0x000000A5 -> tx bytes 0x02,0x00,0xA5,0x00,0x00,0x00 (600 cycles); reply 0xAA -> status 00, rsp_data 0.
REQ-036 op 01, reply 0x55 -> status 01; reply 0xAA with stop bit forced 0 -> status 11.
REQ-037 HEDIOS_HOST_TIMEOUT_EN defined, no reply -> rsp_valid exactly TIMEOUT_CYCLES+1 cycles after last stop bit, status 10; undefined -> busy stays high.
REQ-038 rst pulsed at byte 3 of TX -> tx_line high same cycle, no rsp_valid; next request completes normally; rx traffic in IDLE ignored.
